// File: rtl/breathing_light_pkg.sv
// Shared mode and ramp-direction encodings for the breathing light array.
package breathing_light_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF     = 2'b00;
    localparam mode_t MODE_ON      = 2'b01;
    localparam mode_t MODE_BREATHE = 2'b10;
    localparam mode_t MODE_BLINK   = 2'b11;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } dir_t;

endpackage

// File: rtl/breath_channel.sv
// One light channel: triangular level ramp, period-boundary latch and registered output mux.
module breath_channel
    import breathing_light_pkg::*;
#(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned INIT_LEVEL = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                sync,
    input  logic                en,
    input  logic                boundary,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  mode_t               mode,
    output logic                light
);

    localparam logic [PWM_BITS-1:0] MAX  = '1;
    localparam logic [PWM_BITS-1:0] INIT = PWM_BITS'(INIT_LEVEL);

    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] duty;
    dir_t                dir;
    dir_t                dir_q;
    mode_t               mode_q;
    logic                drive;

    always_comb begin
        drive = 1'b0;
        unique case (mode_q)
            MODE_OFF:     drive = 1'b0;
            MODE_ON:      drive = 1'b1;
            MODE_BREATHE: drive = (pwm_cnt < duty);
            MODE_BLINK:   drive = (dir_q == DirUp);
            default:      drive = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level  <= INIT;
            dir    <= DirUp;
            duty   <= '0;
            dir_q  <= DirUp;
            mode_q <= MODE_OFF;
            light  <= 1'b0;
        end else begin
            // sync has priority over a coincident tick
            if (sync) begin
                level <= INIT;
                dir   <= DirUp;
            end else if (tick && en) begin
                if (dir == DirUp) begin
                    if (level == MAX) begin
                        dir   <= DirDown;
                        level <= MAX - 1'b1;
                    end else begin
                        level <= level + 1'b1;
                    end
                end else begin
                    if (level == '0) begin
                        dir   <= DirUp;
                        level <= {{(PWM_BITS-1){1'b0}}, 1'b1};
                    end else begin
                        level <= level - 1'b1;
                    end
                end
            end
            // Latch only at the last PWM count so a period never mixes settings
            if (boundary) begin
                mode_q <= mode;
                duty   <= level;
                dir_q  <= dir;
            end
            light <= en && drive;
        end
    end

endmodule

// File: rtl/breathing_light_array.sv
// Multi-channel breathing light: shared PWM counter and step prescaler driving per-channel ramps.
module breathing_light_array
    import breathing_light_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned STEP_DIV = 19531
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  sync,
    input  logic [2*CHANNELS-1:0] mode,
    output logic [CHANNELS-1:0]   light,
    output logic                  period_start
);

    localparam int unsigned           PRESC_BITS = $clog2(STEP_DIV);
    localparam logic [PRESC_BITS-1:0] PRESC_LAST = PRESC_BITS'(STEP_DIV - 1);

    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [PRESC_BITS-1:0] presc;
    logic                  tick;
    logic                  boundary;

    assign boundary = (pwm_cnt == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt      <= '0;
            presc        <= '0;
            tick         <= 1'b0;
            period_start <= 1'b0;
        end else begin
            pwm_cnt      <= pwm_cnt + 1'b1;
            period_start <= (pwm_cnt == '0);
            tick         <= en && !sync && (presc == PRESC_LAST);
            if (sync) begin
                presc <= '0;
            end else if (en) begin
                presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        breath_channel #(
            .PWM_BITS   (PWM_BITS),
            .INIT_LEVEL (int'((i * (1 << PWM_BITS)) / CHANNELS))
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick     (tick),
            .sync     (sync),
            .en       (en),
            .boundary (boundary),
            .pwm_cnt  (pwm_cnt),
            .mode     (mode[2*i +: 2]),
            .light    (light[i])
        );
    end

endmodule

// File: tb/tb_breathing_light_array.sv
// Self-checking bench: triangle-position reference model plus hand-derived sequences and vectors.
module tb_breathing_light_array;

    localparam int CH   = 4;
    localparam int PB   = 4;
    localparam int SD   = 4;
    localparam int MAXV = 15;
    localparam int NPER = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic            sync = 1'b0;
    logic [2*CH-1:0] mode = '0;
    logic [CH-1:0]   light;
    logic            period_start;

    always #5 clk = ~clk;

    breathing_light_array #(
        .CHANNELS (CH),
        .PWM_BITS (PB),
        .STEP_DIV (SD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sync         (sync),
        .mode         (mode),
        .light        (light),
        .period_start (period_start)
    );

    int checks = 0;
    int errors = 0;

    // Model: each channel is a position q along an unbounded triangle walk.
    int         m_pwm, m_presc, cyc, last_pwm;
    bit         m_tick;
    int         q[CH];
    logic [1:0] m_mode[CH];
    int         m_duty[CH];
    bit         m_dirup[CH];
    logic [3:0] exp_light;
    bit         exp_ps;

    function automatic int offset(input int i);
        return (i * NPER) / CH;
    endfunction

    function automatic int lvl(input int qq);
        int p;
        p = qq % (2 * MAXV);
        return (p <= MAXV) ? p : 2 * MAXV - p;
    endfunction

    function automatic bit dirup(input int qq);
        int p;
        p = qq % (2 * MAXV);
        return (p >= 1 && p <= MAXV) || qq == 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pwm = 0; m_presc = 0; m_tick = 0; cyc = 0; last_pwm = -1;
        for (int i = 0; i < CH; i++) begin
            q[i] = offset(i); m_mode[i] = 2'b00; m_duty[i] = 0; m_dirup[i] = 1'b1;
        end
        exp_light = '0; exp_ps = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] nl;
        bit b, ntick;
        for (int i = 0; i < CH; i++) begin
            case (m_mode[i])
                2'b00:   b = 1'b0;
                2'b01:   b = 1'b1;
                2'b10:   b = (m_pwm < m_duty[i]);
                default: b = m_dirup[i];
            endcase
            nl[i] = en && b;
        end
        exp_ps = (m_pwm == 0);
        if (m_pwm == MAXV) begin
            for (int i = 0; i < CH; i++) begin
                m_mode[i]  = mode[2*i +: 2];
                m_duty[i]  = lvl(q[i]);
                m_dirup[i] = dirup(q[i]);
            end
        end
        for (int i = 0; i < CH; i++) begin
            if (sync) q[i] = offset(i);
            else if (m_tick && en) q[i]++;
        end
        ntick = en && !sync && (m_presc == SD - 1);
        if (sync) m_presc = 0;
        else if (en) m_presc = (m_presc + 1) % SD;
        m_tick    = ntick;
        last_pwm  = m_pwm;
        m_pwm     = (m_pwm + 1) % NPER;
        exp_light = nl;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        chk("light", 32'(light), 32'(exp_light));
        chk("period_start", 32'(period_start), 32'(exp_ps));
    endtask

    task automatic wait_pwm(input int target);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (last_pwm != target && n < 20);
        if (last_pwm != target) begin
            errors++;
            $display("FAIL wait_pwm timeout: got %0d expected %0d", last_pwm, target);
        end
    endtask

    typedef struct {
        logic [7:0] mode;
        logic       en;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[5];
    int   cnt[CH];

    initial begin
        vecs[0] = '{mode: 8'h55, en: 1'b1, exp: 4'b1111};
        vecs[1] = '{mode: 8'h00, en: 1'b1, exp: 4'b0000};
        vecs[2] = '{mode: 8'h11, en: 1'b1, exp: 4'b0101};
        vecs[3] = '{mode: 8'h44, en: 1'b1, exp: 4'b1010};
        vecs[4] = '{mode: 8'h55, en: 1'b0, exp: 4'b0000};

        // Reset
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_light", 32'(light), 32'd0);
        chk("reset_ps", 32'(period_start), 32'd0);
        rst_n = 1'b1;
        en    = 1'b1;

        // All OFF: lights low, period_start every 16 clk
        for (int k = 0; k < 24; k++) begin
            cycle();
            chk("off_light", 32'(light), 32'd0);
            chk("off_ps", 32'(period_start), 32'((cyc % NPER) == 1));
        end

        // sync coincident with tick at cycle 25, all BREATHE; five ticks land before latch at 48
        mode = 8'hAA;
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        while (cyc < 48) cycle();
        for (int i = 0; i < CH; i++) cnt[i] = 0;
        for (int k = 0; k < NPER; k++) begin
            cycle();
            if (k == 0) chk("breathe_first_high", 32'(light[0]), 32'd1);
            if (k == 5) chk("breathe_first_low", 32'(light[0]), 32'd0);
            for (int i = 0; i < CH; i++) cnt[i] += int'(light[i]);
        end
        chk("duty_ch0", cnt[0], 5);
        chk("duty_ch1", cnt[1], 9);
        chk("duty_ch2", cnt[2], 13);
        chk("duty_ch3", cnt[3], 13);

        // Long ramp: ch1 BREATHE, ch0 BLINK, through both turnarounds
        mode = 8'b00_00_10_11;
        repeat (150) cycle();

        // ch2 ON -> OFF at pwm_cnt 7 holds until the next period start
        mode = 8'h10;
        wait_pwm(MAXV);
        wait_pwm(6);
        mode = 8'h00;
        do begin
            cycle();
            chk("hold_ch2", 32'(light[2]), 32'd1);
        end while (last_pwm != MAXV);
        cycle();
        chk("off_ch2", 32'(light[2]), 32'd0);

        // en low for 40 clk
        mode = 8'hAA;
        repeat (40) cycle();
        en = 1'b0;
        repeat (40) begin
            cycle();
            chk("en_low_light", 32'(light), 32'd0);
        end
        en = 1'b1;
        repeat (80) cycle();

        // Static-mode vectors, checked over a whole period after the latch
        foreach (vecs[v]) begin
            mode = vecs[v].mode;
            en   = vecs[v].en;
            wait_pwm(MAXV);
            for (int k = 0; k < NPER; k++) begin
                cycle();
                chk($sformatf("vec%0d", v), 32'(light), 32'(vecs[v].exp));
            end
        end
        en = 1'b1;

        // Random stimulus against the model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) mode = 8'($urandom);
            en   = ($urandom_range(0, 15) != 0);
            sync = ($urandom_range(0, 63) == 0);
            cycle();
        end
        sync = 1'b0;
        en   = 1'b1;
        mode = 8'hAA;
        repeat (37) cycle();

        // Async reset mid-period
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_light", 32'(light), 32'd0);
        chk("async_rst_ps", 32'(period_start), 32'd0);
        @(negedge clk);
        chk("async_hold_light", 32'(light), 32'd0);
        model_reset();
        mode = 8'b11_10_01_10;
        rst_n = 1'b1;
        repeat (120) cycle();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 29) == 0) mode = 8'($urandom);
            sync = ($urandom_range(0, 79) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
